data_mem_responder: RTL and testbench

Memory-side responder for the core's data-memory port. It accepts one load/store request at a time over a valid/ready handshake and holds it for a programmable number of wait states. It then performs a byte-enabled word access on an internal array and returns a one-cycle response pulse carrying read data and an error flag. It replaces the zero-latency combinational data memory so the pipeline can be exercised against realistic multi-cycle memory.

---
 rtl/riscv_mem_pkg.sv | 12 +
 rtl/sram_word_array.sv | 26 ++
 rtl/data_mem_responder.sv | 75 +++++++
 tb/tb_data_mem_responder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared state encoding, byte-enable width and word-address helper for memory responders.
package riscv_mem_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;
    localparam int BE_W = 4;
    function automatic logic [29:0] word_addr(input logic [31:0] addr);
        return addr[31:2];
    endfunction
endpackage

// File: rtl/sram_word_array.sv
// sram_word_array: DEPTH_WORDS x 32 storage with per-byte write enables and a registered read port.
module sram_word_array
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            we,
    input  logic [BE_W-1:0] be,
    input  logic [AW-1:0]   addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    always_ff @(posedge clk)
        if (en && we)
            for (int i = 0; i < BE_W; i++)
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    // stores return zero data so the response bus is clean for writes
    always_ff @(posedge clk or negedge rst)
        if (!rst) rdata <= '0;
        else if (en) rdata <= we ? '0 : mem[addr];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data-memory responder with programmable wait states,
// byte-enabled word access and a one-cycle response pulse.
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    input  logic [BE_W-1:0] req_be,
    output logic            resp_valid,
    output logic [31:0]     resp_rdata,
    output logic            resp_error
);
    localparam int AW = $clog2(DEPTH_WORDS);
    state_t state, state_n;
    logic [3:0] cnt;
    logic [31:0] addr_q, wdata_q;
    logic [BE_W-1:0] be_q;
    logic write_q;
    logic [29:0] wa;
    logic accept, access, err;
    logic [31:0] sram_rdata;
    assign req_ready = rst && state != ST_WAIT;
    assign accept = req_valid && req_ready;
    assign access = state == ST_WAIT && cnt == 4'd0;
    assign wa = word_addr(addr_q);
    assign err = addr_q[1:0] != 2'b00 || {2'b00, wa} >= 32'(DEPTH_WORDS);
    assign resp_valid = state == ST_RESP;
    assign resp_rdata = resp_error ? '0 : sram_rdata;
    always_comb begin
        state_n = state;
        state_n = state == ST_WAIT ? (cnt == 4'd0 ? ST_RESP : ST_WAIT)
                                   : (accept ? ST_WAIT : ST_IDLE);
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            write_q    <= 1'b0;
            resp_error <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
                write_q <= req_write;
                cnt     <= 4'(WAIT_STATES);
            end else if (state == ST_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) resp_error <= err;
        end
    // the array is only touched on a clean access edge; errors leave it untouched
    sram_word_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_sram (
        .clk   (clk),
        .rst   (rst),
        .en    (access && !err),
        .we    (write_q),
        .be    (be_q),
        .addr  (wa[AW-1:0]),
        .wdata (wdata_q),
        .rdata (sram_rdata)
    );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed scoreboard bench for data_mem_responder (WAIT_STATES 2 and 0).
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, resp_valid, resp_error;
    logic [31:0] resp_rdata;

    logic        z_valid = 1'b0, z_write = 1'b0;
    logic [31:0] z_addr = '0, z_wdata = '0;
    logic [3:0]  z_be = '0;
    logic        z_ready, z_resp_valid, z_resp_error;
    logic [31:0] z_resp_rdata;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_z (
        .clk(clk), .rst(rst), .req_valid(z_valid), .req_ready(z_ready),
        .req_write(z_write), .req_addr(z_addr), .req_wdata(z_wdata), .req_be(z_be),
        .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata), .resp_error(z_resp_error)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          due;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int tests = 0, fails = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // response monitor: every pulse must match the oldest queued expectation, on time
    always @(negedge clk)
        if (rst && resp_valid) begin
            if (sb.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                check("resp_rdata", resp_rdata, e.rd);
                check("resp_error", 32'(resp_error), 32'(e.err));
                check("resp_cycle", 32'(cyc), 32'(e.due));
            end
        end

    // drive at a negedge; returns at the negedge after the accept edge with req_valid still high
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                         input logic [31:0] rd, input logic err, input logic track, output int waited);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = b;
        waited = 0;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("ready_timeout", 32'(waited < 50), 32'd1);
        if (track) sb.push_back('{rd, err, cyc + 4});
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int w;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_error", 32'(resp_error), 32'd0);
        rst = 1'b1;
        #1 check("ready_after_rst", 32'(req_ready), 32'd1);

        // zero wait states: store then load with 2-edge latency
        @(negedge clk);
        z_valid = 1'b1; z_write = 1'b1; z_addr = 32'h10; z_wdata = 32'h55AA55AA; z_be = 4'hF;
        @(negedge clk);
        z_valid = 1'b0;
        check("z_store_not_yet", 32'(z_resp_valid), 32'd0);
        @(negedge clk);
        check("z_store_resp", 32'(z_resp_valid), 32'd1);
        check("z_store_err", 32'(z_resp_error), 32'd0);
        z_valid = 1'b1; z_write = 1'b0;
        @(negedge clk);
        z_valid = 1'b0;
        check("z_load_not_yet", 32'(z_resp_valid), 32'd0);
        @(negedge clk);
        check("z_load_resp", 32'(z_resp_valid), 32'd1);
        check("z_load_rdata", z_resp_rdata, 32'h55AA55AA);
        @(negedge clk);
        check("z_pulse_one_cycle", 32'(z_resp_valid), 32'd0);

        // full-word store and readback
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b1, w); req_valid = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1, w); req_valid = 1'b0;
        // single byte lane merge
        issue(1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0, 1'b1, w); req_valid = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 1'b1, w); req_valid = 1'b0;
        // no-op store with no byte enables
        issue(1'b1, 32'h10, 32'h00000000, 4'b0000, 32'h0, 1'b0, 1'b1, w); req_valid = 1'b0;
        // misaligned and out-of-range
        issue(1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, w); req_valid = 1'b0;
        issue(1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, w); req_valid = 1'b0;
        issue(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1'b1, w); req_valid = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 1'b1, w); req_valid = 1'b0;
        // last in-range word
        issue(1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b1, w); req_valid = 1'b0;
        issue(1'b0, 32'hFFC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b1, w); req_valid = 1'b0;
        drain();

        // three loads with req_valid held high: accepted only in IDLE/RESP
        repeat (4) @(negedge clk);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 1'b1, w);
        check("b2b_first_wait", 32'(w), 32'd0);
        issue(1'b0, 32'hFFC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b1, w);
        check("b2b_second_wait", 32'(w), 32'd3);
        issue(1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, w);
        check("b2b_third_wait", 32'(w), 32'd3);
        req_valid = 1'b0;
        drain();

        // reset during an in-flight store drops it
        repeat (2) @(negedge clk);
        issue(1'b1, 32'h20, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 1'b1, w); req_valid = 1'b0;
        drain();
        repeat (2) @(negedge clk);
        issue(1'b1, 32'h20, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b0, w);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_rdata", resp_rdata, 32'd0);
        check("mid_rst_error", 32'(resp_error), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("in_rst_resp_valid", 32'(resp_valid), 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
        end
        issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 1'b1, w); req_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
